// File: rtl/alu_issuer_if.sv
// Handshake and ALU-side bundle for alu_issuer: request in, registered operands out,
// ALU result/flags back, tagged response out.
interface alu_issuer_if #(
    parameter int NUMBITS = 16,
    parameter int TAGW    = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_opcode;
    logic [NUMBITS-1:0] req_a;
    logic [NUMBITS-1:0] req_b;
    logic [TAGW-1:0]    req_tag;

    logic [NUMBITS-1:0] alu_a;
    logic [NUMBITS-1:0] alu_b;
    logic [2:0]         alu_opcode;
    logic [NUMBITS-1:0] alu_result;
    logic               alu_carryout;
    logic               alu_overflow;
    logic               alu_zero;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [NUMBITS-1:0] rsp_result;
    logic [2:0]         rsp_flags;
    logic [TAGW-1:0]    rsp_tag;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_tag,
        output req_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_carryout, alu_overflow, alu_zero,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_tag,
        input  req_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_carryout, alu_overflow, alu_zero,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issuer.sv
// One-in-flight sequencer for the registered ALU with a tagged response FIFO.
// Optional zero-flag consistency checker enabled by ALU_ISSUER_CHECK_EN.
module alu_issuer #(
    parameter int NUMBITS = 16,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4
) (
    input  logic       clk,
    input  logic       reset,
    alu_issuer_if.slave bus,
    output logic       chk_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;

    typedef struct packed {
        logic [NUMBITS-1:0] result;
        logic [2:0]         flags;
        logic [TAGW-1:0]    tag;
    } rsp_t;

    logic [1:0]      state;
    logic [TAGW-1:0] tag_q;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    rsp_t            mem [DEPTH];
    rsp_t            head;
    logic            req_fire, push, pop;

    // Admission reserves the FIFO slot that CAPT will fill two cycles later.
    assign bus.req_ready = reset && (state == IDLE) && (count < CW'(DEPTH));
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign push          = (state == CAPT);
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    assign head           = mem[rd_ptr];
    assign bus.rsp_valid  = (count != '0);
    assign bus.rsp_result = head.result;
    assign bus.rsp_flags  = head.flags;
    assign bus.rsp_tag    = head.tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_opcode <= '0;
            tag_q          <= '0;
        end else begin
            case (state)
                IDLE: if (req_fire) begin
                    bus.alu_a      <= bus.req_a;
                    bus.alu_b      <= bus.req_b;
                    bus.alu_opcode <= bus.req_opcode;
                    tag_q          <= bus.req_tag;
                    state          <= EXEC;
                end
                EXEC:    state <= CAPT;
                CAPT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{result: bus.alu_result,
                                 flags:  {bus.alu_carryout, bus.alu_overflow, bus.alu_zero},
                                 tag:    tag_q};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_ISSUER_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            chk_err <= 1'b0;
        else if (push && (bus.alu_zero != (bus.alu_result == '0)))
            chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: registered ALU model, vector table, scoreboard queue,
// and directed sequences for backpressure, FIFO full, reset and the checker.
module tb_alu_issuer;
    localparam int NUMBITS = 16;
    localparam int TAGW    = 4;
`ifdef ALU_ISSUER_CHECK_EN
    localparam logic CHK_EXP = 1'b1;
`else
    localparam logic CHK_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic chk_err;
    logic bad_zero = 1'b0;

    alu_issuer_if #(.NUMBITS(NUMBITS), .TAGW(TAGW)) bus ();

    alu_issuer #(.NUMBITS(NUMBITS), .DEPTH(4), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result;
        logic [2:0]  flags;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU: 000 uadd, 001 sadd, 010 sub, 011 and, 100 or, 101 xor, 110 shl1, 111 shr1.
    function automatic logic [18:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: {c, r} = {1'b0, a} + {1'b0, b};
            3'd1: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd2: begin {c, r} = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin c = a[15]; r = {a[14:0], 1'b0}; end
            default: begin c = a[0]; r = {1'b0, a[15:1]}; end
        endcase
        return {r, c, v, (r == 16'h0)};
    endfunction

    // Registered ALU; bad_zero misreports the zero flag to exercise the checker.
    always_ff @(posedge clk) begin
        logic [18:0] o;
        o = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);
        bus.alu_result   <= o[18:3];
        bus.alu_carryout <= o[2];
        bus.alu_overflow <= o[1];
        bus.alu_zero     <= bad_zero ? 1'b0 : o[0];
    end

    always @(negedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_tag), 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_result", 32'(bus.rsp_result), 32'(e.result));
                chk("rsp_flags",  32'(bus.rsp_flags),  32'(e.flags));
                chk("rsp_tag",    32'(bus.rsp_tag),    32'(e.tag));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input logic [15:0] er, input logic [2:0] ef);
        bit ok;
        bus.req_opcode = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        bus.req_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("req_accept_timeout", 32'(tag), 32'hFFFF_FFFF);
        else sb.push_back('{result: er, flags: ef, tag: tag});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b;
        logic [15:0] er;
        logic [2:0]  ef;
    } vec_t;
    vec_t vecs[9];

    initial begin
        vecs[0] = '{3'd0, 16'h0001, 16'h0002, 16'h0003, 3'b000};
        vecs[1] = '{3'd1, 16'h7FFF, 16'h0001, 16'h8000, 3'b010};
        vecs[2] = '{3'd2, 16'h0005, 16'h0005, 16'h0000, 3'b001};
        vecs[3] = '{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 3'b100};
        vecs[4] = '{3'd3, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
        vecs[5] = '{3'd4, 16'h1200, 16'h0034, 16'h1234, 3'b000};
        vecs[6] = '{3'd5, 16'hAAAA, 16'h5555, 16'hFFFF, 3'b000};
        vecs[7] = '{3'd6, 16'h8001, 16'h0000, 16'h0002, 3'b100};
        vecs[8] = '{3'd7, 16'h0001, 16'h0000, 16'h0000, 3'b101};

        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        chk("rst_alu_a",      32'(bus.alu_a),      32'd0);
        chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_chk_err",    32'(chk_err),        32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

        // uadd wrap with latency: response visible only after the CAPT edge
        @(posedge clk); #1;
        send(3'd0, 16'hFFFF, 16'h0001, 4'd3, 16'h0000, 3'b101);
        @(negedge clk); chk("lat_exec_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk); chk("lat_capt_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk); chk("lat_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        chk("lat_rsp_result", 32'(bus.rsp_result), 32'h0000);
        chk("lat_rsp_flags",  32'(bus.rsp_flags),  32'b101);
        drain();

        for (int i = 0; i < 9; i++)
            send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].er, vecs[i].ef);
        drain();

        // FIFO full then single pop
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd3, 16'hF0F0, 16'h0FF0, 4'(i), 16'h00F0, 3'b000);
        repeat (3) @(negedge clk);
        chk("full_req_ready", 32'(bus.req_ready), 32'd0);
        chk("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("full_head_tag",  32'(bus.rsp_tag),   32'd0);
        @(posedge clk); #1; bus.rsp_ready = 1'b1;
        @(posedge clk); #1; bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("pop_req_ready", 32'(bus.req_ready), 32'd1);
        chk("pop_head_tag",  32'(bus.rsp_tag),   32'd1);
        drain();

        // pointer wrap with continuous draining
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [15:0] a, b;
            logic [18:0] o;
            a = 16'($urandom); b = 16'($urandom);
            o = alu_ref(3'(i), a, b);
            send(3'(i), a, b, 4'(i), o[18:3], o[2:0]);
        end
        drain();

        // backpressure hold
        bus.rsp_ready = 1'b0;
        send(3'd5, 16'h1234, 16'h1234, 4'd5, 16'h0000, 3'b001);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid",  32'(bus.rsp_valid),  32'd1);
            chk("hold_result", 32'(bus.rsp_result), 32'h0000);
            chk("hold_flags",  32'(bus.rsp_flags),  32'b001);
            chk("hold_tag",    32'(bus.rsp_tag),    32'd5);
        end
        drain();

        // reset during EXEC discards the in-flight op
        bus.rsp_ready = 1'b0;
        bus.req_opcode = 3'd4; bus.req_a = 16'h00FF; bus.req_b = 16'h0F00; bus.req_tag = 4'd9;
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("rstx_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1; bus.req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rstx_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        chk("rstx_req_ready",  32'(bus.req_ready),  32'd0);
        chk("rstx_alu_a",      32'(bus.alu_a),      32'd0);
        chk("rstx_alu_b",      32'(bus.alu_b),      32'd0);
        chk("rstx_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("rstx_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rstx_rsp_flags",  32'(bus.rsp_flags),  32'd0);
        chk("rstx_rsp_tag",    32'(bus.rsp_tag),    32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstx_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("rstx_req_ready_after", 32'(bus.req_ready), 32'd1);

        // zero-flag checker
        @(posedge clk); #1;
        bad_zero = 1'b1;
        send(3'd0, 16'h0000, 16'h0000, 4'd7, 16'h0000, 3'b000);
        drain();
        chk("chk_err_set", 32'(chk_err), 32'(CHK_EXP));
        bad_zero = 1'b0;
        send(3'd0, 16'h0001, 16'h0001, 4'd8, 16'h0002, 3'b000);
        drain();
        chk("chk_err_sticky", 32'(chk_err), 32'(CHK_EXP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issuer.md
# alu_issuer

Request-side sequencer for the team's registered 16-bit ALU. It accepts operation requests over a valid/ready handshake, drives the ALU operand and opcode inputs from registers, and captures the ALU's registered result and flags one cycle later. It returns each result with its tag through a response FIFO with its own valid/ready handshake. It sits between the instruction/test front end and the ALU, and keeps at most one operation in flight.

## Interface
- NUMBITS, 16, operand/result width; must match the ALU
- DEPTH, 4, response FIFO entries; power of two, ≥2
- TAGW, 4, request tag width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_opcode  in  3  ALU opcode (000 uadd … 111 shift-right-1)
- req_a, req_b  in  NUMBITS  operands
- req_tag  in  TAGW  caller tag, returned unchanged
- alu_a, alu_b  out  NUMBITS  registered ALU operands
- alu_opcode  out  3  registered ALU opcode
- alu_result  in  NUMBITS  ALU result (ALU registers on posedge clk)
- alu_carryout, alu_overflow, alu_zero  in  1 each  ALU flags
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer takes head
- rsp_result  out  NUMBITS  head result
- rsp_flags  out  3  head {carryout, overflow, zero}
- rsp_tag  out  TAGW  head tag
- chk_err  out  1  sticky zero-flag mismatch (see Configuration)

## Operation
- FSM states are IDLE, EXEC, CAPT.
- IDLE: req_ready = 1 when fifo_count < DEPTH. On handshake: load alu_a, alu_b, alu_opcode and tag_q from the request, then go to EXEC.
- EXEC: the ALU inputs are stable and the ALU registers its outputs at this cycle's closing edge. req_ready = 0. Go to CAPT.
- CAPT: push {alu_result, flags, tag_q} into the FIFO, then go to IDLE. A slot is always free, because the IDLE admission check reserved it.
- The ALU input registers hold their last values outside IDLE handshakes and are never cleared between operations.
- FIFO behaviour:
  - Head is presented combinationally on the rsp_* outputs.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- rsp_* outputs are held stable while rsp_valid && !rsp_ready.
- The issuer does no arithmetic. Flags pass through exactly as the ALU reports them.

## Timing
- Reset (reset = 0, asynchronous) clears the following:
  - FSM to IDLE
  - FIFO pointers and count to 0
  - alu_a, alu_b, alu_opcode, tag_q to 0
  - chk_err to 0
  - Resulting outputs: rsp_valid = 0, req_ready = 0 while asserted and 1 after release, rsp_* = 0 (memory is cleared).
- Reset mid-EXEC/CAPT: the in-flight operation is discarded and no response is produced.
- Request accepted at edge E0 → EXEC during E0..E1 → CAPT during E1..E2 → FIFO push at E2 → rsp_valid high after E2 when the FIFO was empty.
- Request-to-response latency is 2 cycles. Throughput is one request per 3 cycles.
- FIFO full: req_ready = 0 in IDLE. It rises the cycle after a pop makes fifo_count < DEPTH.
- Pop in the same cycle as the CAPT push with the FIFO previously empty: not possible, since rsp_valid is still 0. The pushed entry becomes visible the next cycle.

## Configuration
- ALU_ISSUER_CHECK_EN defined:
  - In CAPT, compare alu_zero against (alu_result == 0).
  - On a mismatch, set chk_err to 1. It stays at 1 until reset.
  - The check applies to every opcode.
- Undefined: chk_err is tied to 0 and no comparator logic is built.

## Test plan
- Unsigned add: opcode 000, A = 0xFFFF, B = 0x0001, tag 3 → after 2 cycles rsp_result = 0x0000, rsp_flags = 3'b101, rsp_tag = 3.
- Back-to-back: four AND requests (0xF0F0 & 0x0FF0, tags 0–3) with rsp_ready = 0 → four responses queued with result 0x00F0, req_ready = 0 after the fourth; then one pop → req_ready = 1 next cycle, FIFO order preserved.
- Wrap-around: 10 requests with rsp_ready = 1 → tags returned 0..9 in order, count never exceeds DEPTH, pointers wrap cleanly.
- Backpressure hold: rsp_ready = 0 for 5 cycles with an XOR 0x1234 ^ 0x1234 head → rsp_result = 0x0000 and flags 3'b001 remain stable, then pop on rsp_ready = 1.
- Reset mid-EXEC: assert reset one cycle after acceptance → rsp_valid = 0 and all FIFO/ALU registers at 0 immediately; no response after release.
- Checker (ALU_ISSUER_CHECK_EN): the ALU model forces alu_zero = 0 with alu_result = 0x0000 → chk_err = 1 after the CAPT edge and stays set. Without the macro, chk_err stays 0.
